// File: rtl/rps_game_sequencer_if.sv
// Button inputs and display/score outputs of the rock-paper-scissors game controller.
interface rps_game_sequencer_if;
    logic       btn_start;
    logic       btn_rock;
    logic       btn_paper;
    logic       btn_scissors;
    logic [3:0] selector;
    logic [1:0] player_choice;
    logic [1:0] rival_choice;
    logic [3:0] wins;
    logic [3:0] losses;
    logic       busy;

    // Button side / testbench: drives buttons, observes the game.
    modport master (
        output btn_start,
        output btn_rock,
        output btn_paper,
        output btn_scissors,
        input  selector,
        input  player_choice,
        input  rival_choice,
        input  wins,
        input  losses,
        input  busy
    );

    // Game controller side.
    modport slave (
        input  btn_start,
        input  btn_rock,
        input  btn_paper,
        input  btn_scissors,
        output selector,
        output player_choice,
        output rival_choice,
        output wins,
        output losses,
        output busy
    );
endinterface

// File: rtl/rps_game_sequencer.sv
// Rock-paper-scissors game controller: sequences the display messages,
// latches player and rival choices, and keeps saturating scores.
module rps_game_sequencer #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned TIMER_W     = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    rps_game_sequencer_if.slave  bus
);

    localparam int unsigned SEL_W    = 4;
    localparam int unsigned CHOICE_W = 2;
    localparam int unsigned SCORE_W  = 4;

    // FSM encoding
    localparam logic [2:0] ST_START            = 3'd0;
    localparam logic [2:0] ST_SELECT           = 3'd1;
    localparam logic [2:0] ST_SHOW_PLAYER      = 3'd2;
    localparam logic [2:0] ST_SHOW_RIVAL_LABEL = 3'd3;
    localparam logic [2:0] ST_SHOW_RIVAL       = 3'd4;
    localparam logic [2:0] ST_RESULT           = 3'd5;

    // Display message codes
    localparam logic [SEL_W-1:0] MSG_START    = 4'd0;
    localparam logic [SEL_W-1:0] MSG_SELECT   = 4'd1;
    localparam logic [SEL_W-1:0] MSG_PAPER    = 4'd2;
    localparam logic [SEL_W-1:0] MSG_SCISSORS = 4'd3;
    localparam logic [SEL_W-1:0] MSG_ROCK     = 4'd4;
    localparam logic [SEL_W-1:0] MSG_RIVAL    = 4'd5;
    localparam logic [SEL_W-1:0] MSG_WON      = 4'd6;
    localparam logic [SEL_W-1:0] MSG_LOST     = 4'd7;
    localparam logic [SEL_W-1:0] MSG_TIE      = 4'd8;

    // Choice encoding
    localparam logic [CHOICE_W-1:0] CH_ROCK     = 2'd0;
    localparam logic [CHOICE_W-1:0] CH_PAPER    = 2'd1;
    localparam logic [CHOICE_W-1:0] CH_SCISSORS = 2'd2;

    localparam logic [SCORE_W-1:0]  SCORE_MAX = 4'd15;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

    logic [2:0]          state, state_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [1:0]          rival_ctr, rival_ctr_d;
    logic                prev_start, prev_rock, prev_paper, prev_scissors;
    logic [SEL_W-1:0]    selector_q, selector_d;
    logic [CHOICE_W-1:0] player_q, player_d;
    logic [CHOICE_W-1:0] rival_q, rival_d;
    logic [SCORE_W-1:0]  wins_q, wins_d;
    logic [SCORE_W-1:0]  losses_q, losses_d;
    logic                busy_q, busy_d;

    logic                start_pulse, rock_pulse, paper_pulse, scissors_pulse;
    logic [1:0]          choice_count;
    logic [CHOICE_W-1:0] pressed_choice;
    logic                timer_done;
    logic [2:0]          diff_raw;
    logic [2:0]          diff_mod;

    // Message code shown for a given choice.
    function automatic logic [SEL_W-1:0] choice_msg(input logic [CHOICE_W-1:0] ch);
        logic [SEL_W-1:0] msg;
        case (ch)
            CH_PAPER:    msg = MSG_PAPER;
            CH_SCISSORS: msg = MSG_SCISSORS;
            default:     msg = MSG_ROCK;
        endcase
        return msg;
    endfunction

    // Rising-edge detection on the debounced buttons.
    always_comb begin
        start_pulse    = bus.btn_start    & ~prev_start;
        rock_pulse     = bus.btn_rock     & ~prev_rock;
        paper_pulse    = bus.btn_paper    & ~prev_paper;
        scissors_pulse = bus.btn_scissors & ~prev_scissors;
        choice_count   = 2'(rock_pulse) + 2'(paper_pulse) + 2'(scissors_pulse);
        if (paper_pulse) begin
            pressed_choice = CH_PAPER;
        end else if (scissors_pulse) begin
            pressed_choice = CH_SCISSORS;
        end else begin
            pressed_choice = CH_ROCK;
        end
    end

    // Outcome: (player - rival) mod 3, 0 tie / 1 win / 2 loss.
    always_comb begin
        diff_raw = 3'(player_q) + 3'd3 - 3'(rival_q);
        diff_mod = (diff_raw >= 3'd3) ? (diff_raw - 3'd3) : diff_raw;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        timer_d     = timer;
        selector_d  = selector_q;
        player_d    = player_q;
        rival_d     = rival_q;
        wins_d      = wins_q;
        losses_d    = losses_q;
        busy_d      = busy_q;
        rival_ctr_d = (rival_ctr == 2'd2) ? 2'd0 : (rival_ctr + 2'd1);
        timer_done  = (timer == TIMER_LAST);

        case (state)
            ST_START: begin
                selector_d = MSG_START;
                busy_d     = 1'b0;
                if (start_pulse) begin
                    state_d    = ST_SELECT;
                    selector_d = MSG_SELECT;
                end
            end
            ST_SELECT: begin
                if (choice_count == 2'd1) begin
                    state_d    = ST_SHOW_PLAYER;
                    player_d   = pressed_choice;
                    rival_d    = rival_ctr;
                    timer_d    = '0;
                    selector_d = choice_msg(pressed_choice);
                    busy_d     = 1'b1;
                end
            end
            ST_SHOW_PLAYER: begin
                if (timer_done) begin
                    state_d    = ST_SHOW_RIVAL_LABEL;
                    timer_d    = '0;
                    selector_d = MSG_RIVAL;
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            ST_SHOW_RIVAL_LABEL: begin
                if (timer_done) begin
                    state_d    = ST_SHOW_RIVAL;
                    timer_d    = '0;
                    selector_d = choice_msg(rival_q);
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            ST_SHOW_RIVAL: begin
                if (timer_done) begin
                    state_d = ST_RESULT;
                    timer_d = '0;
                    busy_d  = 1'b0;
                    case (diff_mod)
                        3'd1: begin
                            selector_d = MSG_WON;
                            if (wins_q != SCORE_MAX) begin
                                wins_d = wins_q + SCORE_W'(1);
                            end
                        end
                        3'd2: begin
                            selector_d = MSG_LOST;
                            if (losses_q != SCORE_MAX) begin
                                losses_d = losses_q + SCORE_W'(1);
                            end
                        end
                        default: selector_d = MSG_TIE;
                    endcase
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            ST_RESULT: begin
                busy_d = 1'b0;
                if (start_pulse) begin
                    state_d    = ST_SELECT;
                    selector_d = MSG_SELECT;
                end
            end
            default: begin
                state_d    = ST_START;
                timer_d    = '0;
                selector_d = MSG_START;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_START;
            timer         <= '0;
            rival_ctr     <= 2'd0;
            prev_start    <= 1'b0;
            prev_rock     <= 1'b0;
            prev_paper    <= 1'b0;
            prev_scissors <= 1'b0;
            selector_q    <= MSG_START;
            player_q      <= CH_ROCK;
            rival_q       <= CH_ROCK;
            wins_q        <= '0;
            losses_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            rival_ctr     <= rival_ctr_d;
            prev_start    <= bus.btn_start;
            prev_rock     <= bus.btn_rock;
            prev_paper    <= bus.btn_paper;
            prev_scissors <= bus.btn_scissors;
            selector_q    <= selector_d;
            player_q      <= player_d;
            rival_q       <= rival_d;
            wins_q        <= wins_d;
            losses_q      <= losses_d;
            busy_q        <= busy_d;
        end
    end

    // Drive the registered values onto the interface.
    assign bus.selector      = selector_q;
    assign bus.player_choice = player_q;
    assign bus.rival_choice  = rival_q;
    assign bus.wins          = wins_q;
    assign bus.losses        = losses_q;
    assign bus.busy          = busy_q;

endmodule

// File: doc/rps_game_sequencer.md
Name: rps_game_sequencer

Overview:
- Game controller for the rock-paper-scissors lab.
- Sequences the 8-digit text display by driving its 4-bit message selector through start, select, player choice, rival label, rival choice and result.
- Latches the player's button choice and generates the rival choice.
- Keeps saturating win and loss scores.
- Sits between the debounced button inputs and the text display block.

Parameters:
- HOLD_CYCLES, 50000000: clock cycles each timed message stays on the display.
- TIMER_W, 26: width of the hold timer. Must satisfy 2^TIMER_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn_start  in  1  start/restart button (synchronized and debounced upstream)
- btn_rock  in  1  rock choice button
- btn_paper  in  1  paper choice button
- btn_scissors  in  1  scissors choice button
- selector  out  4  message code to the display: 0 start, 1 select, 2 paper, 3 scissors, 4 rock, 5 rival, 6 you won, 7 you lost, 8 tie
- player_choice  out  2  latched player choice: 0 rock, 1 paper, 2 scissors
- rival_choice  out  2  latched rival choice, same encoding
- wins  out  4  win count, saturating at 15
- losses  out  4  loss count, saturating at 15
- busy  out  1  high in the timed display states

Behaviour:
- Reset: applied when reset==0 at posedge clk. Values after reset:
  - state START, selector=0
  - player_choice=0, rival_choice=0, wins=0, losses=0, busy=0
  - timer=0, rival_ctr=0
  - button history registers=0
- Edge detect: each button has a history flop; pulse = btn & ~btn_prev. A button already held high when reset is released produces one pulse on the first active cycle.
- rival_ctr: 2-bit counter, increments every non-reset cycle and wraps 0→1→2→0. Its value in cycle k after reset release is k mod 3.
- All outputs are registered. selector changes on the same clock edge as the state transition.
- State START (selector 0): btn_start pulse → SELECT. All other buttons are ignored.
- State SELECT (selector 1):
  - Exactly one choice pulse in a cycle → latch player_choice, latch rival_choice=rival_ctr, clear timer, go to SHOW_PLAYER.
  - Two or three simultaneous choice pulses → ignored, stay in SELECT.
  - btn_start is ignored.
- Timed states: SHOW_PLAYER → SHOW_RIVAL_LABEL → SHOW_RIVAL → RESULT.
  - Each timed state lasts exactly HOLD_CYCLES cycles: the timer counts 0..HOLD_CYCLES-1, then the state advances and the timer clears.
  - busy=1 in all three timed states.
  - All button pulses are ignored while busy.
- Selector per state:
  - SHOW_PLAYER: choice code (rock 4, paper 2, scissors 3).
  - SHOW_RIVAL_LABEL: 5.
  - SHOW_RIVAL: rival choice code, same mapping.
- Result rule, computed on the transition into RESULT:
  - d = (player_choice − rival_choice) mod 3.
  - d=0 → selector 8 (tie), no score change.
  - d=1 → selector 6 (won), wins += 1.
  - d=2 → selector 7 (lost), losses += 1.
  - Score counters stick at 15; no wrap to 0.
- State RESULT: holds indefinitely, busy=0. btn_start pulse → SELECT. player_choice, rival_choice and scores are retained.
- Reset mid-game: reset in any state returns to START within one cycle and clears the scores. No partial score update occurs.
- Illegal state encoding → START on the next clock.

Test Plan (HOLD_CYCLES=4):
1. Reset, then btn_start pulse → selector 0→1 on the edge after the pulse; busy=0.
2. In SELECT, press rock when rival_ctr==1 → selector 4 for 4 cycles, 5 for 4, 2 for 4, then 7; losses=1, wins=0, busy is low in the first RESULT cycle.
3. Press paper when rival_ctr==0 → display sequence ends at selector 6, wins increments. Press scissors when rival_ctr==2 → ends at selector 8, scores unchanged.
4. In SELECT, pulse rock and paper together → stays at selector 1. Pulse buttons during SHOW_RIVAL_LABEL → no effect on the sequence or choices.
5. Play 17 winning rounds (rock vs rival scissors) → wins reaches 15 and stays at 15; losses=0.
6. Assert reset during SHOW_RIVAL, with wins=3 → next cycle selector=0, wins=0, busy=0. A held btn_start at reset release → one pulse only, selector=1.
